// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: table entry layout and 2-bit counter encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

    // Default geometry; the entry layout below is sized from these values.
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_ADDR_WIDTH = 32;
    localparam int BP_TAG_W      = BP_ADDR_WIDTH - BP_INDEX_BITS - 2;

    // Two-bit saturating direction counter encodings.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Counter value loaded into every entry on reset (weakly not-taken).
    localparam logic [1:0] BP_CTR_RESET = WNT;

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W-1:0]      tag;
        logic [BP_ADDR_WIDTH-1:0] target;
        logic [1:0]               ctr;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state rule for a 2-bit saturating branch-direction counter.
// Latency: purely combinational.
// Backpressure: none.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward strongly-taken on taken, toward strongly-not-taken otherwise; hold at the ends.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with execute-stage update and mispredict flush.
// Latency: lookup and flush are combinational; table updates visible the cycle after upd_valid.
// Backpressure: none; one update accepted every cycle. Optional perf counters via BP_PERF_CNT_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_BF,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] next_pc,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_taken,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  rst_out,
    output logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]           br_count,
    output logic [31:0]           mispred_count
`endif
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    bp_entry_t table_q [DEPTH];

    // Fetch-side lookup
    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]      f_tag;
    bp_entry_t             f_ent;
    logic                  f_hit;

    // Update-side access
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    bp_entry_t             u_ent;
    logic                  u_hit;
    logic                  upd_en;
    logic [1:0]            ctr_next;
    logic                  upd_we_d;
    bp_entry_t             upd_ent_d;

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign f_ent = table_q[f_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

    assign u_idx = upd_pc[INDEX_BITS+1:2];
    assign u_tag = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign u_ent = table_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    // Updates arriving while reset is held are dropped entirely, including their flush.
    assign upd_en = upd_valid && !rst_BF;

    // Prediction reads the registered table, so a same-cycle update is not yet visible here.
    assign pred_taken = !rst_BF && f_hit && f_ent.ctr[1];
    assign next_pc    = pred_taken ? f_ent.target : fetch_pc + ADDR_WIDTH'(4);

    assign rst_out     = upd_en && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_WIDTH'(4);

    bp_sat_counter u_sat_counter (
        .ctr_i   (u_ent.ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_next)
    );

    // Build the new entry: train a hit, allocate a taken miss, leave a not-taken miss alone.
    always_comb begin
        upd_we_d  = 1'b0;
        upd_ent_d = u_ent;
        if (upd_en) begin
            if (u_hit) begin
                upd_we_d      = 1'b1;
                upd_ent_d.ctr = ctr_next;
                if (upd_taken) upd_ent_d.target = upd_target;
            end else if (upd_taken) begin
                upd_we_d  = 1'b1;
                upd_ent_d = '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WT};
            end
        end
    end

    // Table write; reset wins over any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_BF) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_RESET};
            end
        end else if (upd_we_d) begin
            table_q[u_idx] <= upd_ent_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    // Resolved-branch and flush event counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst_BF) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (upd_en)  br_cnt_q  <= br_cnt_q + 32'd1;
            if (rst_out) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_predictor;

    logic        clk;
    logic        rst_BF;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        rst_out;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] br_count;
    logic [31:0] mispred_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst_BF          (rst_BF),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .next_pc         (next_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .rst_out         (rst_out),
        .redirect_pc     (redirect_pc)
`ifdef BP_PERF_CNT_EN
        ,
        .br_count        (br_count),
        .mispred_count   (mispred_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-slot arrays, counters kept as plain integers 0..3.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          chk_en = 1'b0;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic bit model_mispred();
        return !rst_BF && upd_valid &&
               ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    always @(posedge clk) begin
        int s;
        if (rst_BF) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_br   = 0;
            m_mis  = 0;
            chk_en = 1'b1;
        end else if (upd_valid) begin
            s = slot_of(upd_pc);
            m_br = m_br + 1;
            if (model_mispred()) m_mis = m_mis + 1;
            if (m_valid[s] && m_tag[s] == upd_pc / 32'd256) begin
                if (upd_taken) begin
                    if (m_ctr[s] < 3) m_ctr[s] = m_ctr[s] + 1;
                    m_tgt[s] = upd_target;
                end else if (m_ctr[s] > 0) begin
                    m_ctr[s] = m_ctr[s] - 1;
                end
            end else if (upd_taken) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = upd_pc / 32'd256;
                m_tgt[s]   = upd_target;
                m_ctr[s]   = 2;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int          s      = slot_of(fetch_pc);
            automatic bit          e_hit  = m_valid[s] && (m_tag[s] == fetch_pc / 32'd256);
            automatic bit          e_pred = !rst_BF && e_hit && (m_ctr[s] >= 2);
            automatic logic [31:0] e_next = e_pred ? m_tgt[s] : fetch_pc + 32'd4;
            automatic bit          e_mis  = model_mispred();
            chk("model pred_taken", {31'd0, pred_taken}, {31'd0, e_pred});
            chk("model next_pc", next_pc, e_next);
            chk("model rst_out", {31'd0, rst_out}, {31'd0, e_mis});
            if (e_mis) chk("model redirect_pc", redirect_pc,
                           upd_taken ? upd_target : upd_pc + 32'd4);
`ifdef BP_PERF_CNT_EN
            chk("model br_count", br_count, m_br);
            chk("model mispred_count", mispred_count, m_mis);
`endif
        end
    end

    task automatic drive(input bit rst, input logic [31:0] fpc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                         input bit upt, input logic [31:0] uptgt);
        rst_BF          = rst;
        fetch_pc        = fpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_only(input logic [31:0] fpc);
        drive(1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset held with a would-be mispredict on the update port: everything quiet.
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("rst pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst next_pc", next_pc, 32'h104);
        chk("rst rst_out", {31'd0, rst_out}, 32'd0);
        next_cycle();
        drive(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        next_cycle();

        // Empty table: fall-through.
        fetch_only(32'h100);
        chk("cold pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("cold next_pc", next_pc, 32'h104);
        next_cycle();

        // Allocate at 0x100 while fetching 0x100: old prediction this cycle, flush to 0x80.
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("alloc same-cycle pred", {31'd0, pred_taken}, 32'd0);
        chk("alloc rst_out", {31'd0, rst_out}, 32'd1);
        chk("alloc redirect_pc", redirect_pc, 32'h80);
        next_cycle();
        fetch_only(32'h100);
        chk("after alloc pred", {31'd0, pred_taken}, 32'd1);
        chk("after alloc next_pc", next_pc, 32'h80);
        next_cycle();

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10.
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("nt1 rst_out", {31'd0, rst_out}, 32'd1);
        chk("nt1 redirect_pc", redirect_pc, 32'h104);
        next_cycle();
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ctr01 pred", {31'd0, pred_taken}, 32'd0);
        chk("nt2 rst_out", {31'd0, rst_out}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("ctr00 pred", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("ctr01 again pred", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        fetch_only(32'h100);
        chk("ctr10 pred", {31'd0, pred_taken}, 32'd1);
        chk("ctr10 next_pc", next_pc, 32'h80);
        next_cycle();

        // Correct prediction: no flush. Then right direction, wrong target: flush.
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("correct rst_out", {31'd0, rst_out}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("bad target rst_out", {31'd0, rst_out}, 32'd1);
        chk("bad target redirect", redirect_pc, 32'h90);
        next_cycle();
        fetch_only(32'h100);
        chk("new target next_pc", next_pc, 32'h90);
        next_cycle();

        // Alias at 0x200 replaces the 0x100 entry.
        drive(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        chk("alias miss pred", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        fetch_only(32'h100);
        chk("aliased 0x100 pred", {31'd0, pred_taken}, 32'd0);
        chk("aliased 0x100 next", next_pc, 32'h104);
        next_cycle();
        fetch_only(32'h200);
        chk("alias 0x200 next", next_pc, 32'h300);
        next_cycle();

        // Not-taken miss at the same slot leaves the table alone.
        drive(1'b0, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        fetch_only(32'h200);
        chk("nt miss keeps entry", {31'd0, pred_taken}, 32'd1);
        next_cycle();

        // Other slot and address wrap.
        fetch_only(32'h104);
        chk("slot1 next_pc", next_pc, 32'h108);
        next_cycle();
        drive(1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        chk("wrap next_pc", next_pc, 32'h0);
        chk("wrap redirect_pc", redirect_pc, 32'h0);
        next_cycle();

        // Reset overriding a same-cycle allocate.
        drive(1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h500, 1'b0, 32'h0);
        chk("mid rst rst_out", {31'd0, rst_out}, 32'd0);
        chk("mid rst pred", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        fetch_only(32'h200);
        chk("post rst 0x200 pred", {31'd0, pred_taken}, 32'd0);
        next_cycle();
        fetch_only(32'h104);
        chk("post rst 0x104 next", next_pc, 32'h108);
        next_cycle();

`ifdef BP_PERF_CNT_EN
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h10, 1'b1, 32'h10, (i < 3), 32'h40, 1'b0, 32'h0);
            next_cycle();
        end
        fetch_only(32'h10);
        chk("perf br_count", br_count, 32'd10);
        chk("perf mispred_count", mispred_count, 32'd3);
        next_cycle();
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        fetch_only(32'h10);
        chk("perf br_count clr", br_count, 32'd0);
        chk("perf mispred clr", mispred_count, 32'd0);
        chk("perf table empty", {31'd0, pred_taken}, 32'd0);
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
